// File: rtl/stepper_axis_ctrl_if.sv
// rtl/stepper_axis_ctrl_if.sv - command, limit-switch and driver signals of one stepper channel
// Optional position counter signals are present when STEPPER_POSITION_EN is defined.
interface stepper_axis_ctrl_if;
  logic        cmd_start;
  logic [31:0] cmd_steps;
  logic [31:0] cmd_period;
  logic        cmd_abort;
  logic        endstop_min;
  logic        endstop_max;
  logic        step_out;
  logic        dir_out;
  logic        enable_n_out;
  logic        busy;
  logic        done;
  logic        hit_endstop;
  logic [31:0] steps_left;
`ifdef STEPPER_POSITION_EN
  logic        pos_clear;
  logic [31:0] position;
`endif

  modport master (
    output cmd_start,
    output cmd_steps,
    output cmd_period,
    output cmd_abort,
    output endstop_min,
    output endstop_max,
`ifdef STEPPER_POSITION_EN
    output pos_clear,
    input  position,
`endif
    input  step_out,
    input  dir_out,
    input  enable_n_out,
    input  busy,
    input  done,
    input  hit_endstop,
    input  steps_left
  );

  modport slave (
    input  cmd_start,
    input  cmd_steps,
    input  cmd_period,
    input  cmd_abort,
    input  endstop_min,
    input  endstop_max,
`ifdef STEPPER_POSITION_EN
    input  pos_clear,
    output position,
`endif
    output step_out,
    output dir_out,
    output enable_n_out,
    output busy,
    output done,
    output hit_endstop,
    output steps_left
  );
endinterface

// File: rtl/stepper_axis_ctrl.sv
// rtl/stepper_axis_ctrl.sv - single-axis step/direction sequencer with endstops and abort
// Define STEPPER_POSITION_EN to add the signed position counter and pos_clear input.
module stepper_axis_ctrl #(
  parameter int unsigned PULSE_W    = 100,
  parameter int unsigned DIR_SETUP  = 50,
  parameter int unsigned MIN_PERIOD = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  stepper_axis_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_e;

  localparam logic [31:0] PULSE_LAST = 32'(PULSE_W - 1);
  localparam logic [31:0] PULSE_LEN  = 32'(PULSE_W);
  localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP);
  localparam logic [31:0] MIN_P      = 32'(MIN_PERIOD);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] steps_q, steps_d;
  logic [31:0] period_q, period_d;
  logic        dir_q, dir_d;
  logic        hit_q, hit_d;
  logic        step_q, step_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        en_n_q, en_n_d;
  logic [1:0]  es_min_sync_q, es_max_sync_q;
`ifdef STEPPER_POSITION_EN
  logic [31:0] pos_q, pos_d;
`endif

  logic [31:0] steps_abs;
  logic [31:0] period_eff;
  logic [31:0] low_last;
  logic        es_block;
  logic        go_high;

  // Two's complement negate also maps 0x80000000 onto itself, which is the wanted magnitude.
  assign steps_abs  = bus.cmd_steps[31] ? (~bus.cmd_steps + 32'd1) : bus.cmd_steps;
  assign period_eff = (bus.cmd_period < MIN_P) ? MIN_P : bus.cmd_period;
  assign low_last   = period_q - PULSE_LEN - 32'd1;
  assign es_block   = dir_q ? es_max_sync_q[1] : es_min_sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    period_d = period_q;
    dir_d    = dir_q;
    hit_d    = hit_q;
    go_high  = 1'b0;
`ifdef STEPPER_POSITION_EN
    pos_d    = pos_q;
    if (bus.pos_clear && !busy_q) begin
      pos_d = 32'd0;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_start && !bus.cmd_abort) begin
          steps_d  = steps_abs;
          dir_d    = ~bus.cmd_steps[31];
          period_d = period_eff;
          hit_d    = 1'b0;
          cnt_d    = 32'd0;
          state_d  = (steps_abs == 32'd0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (bus.cmd_abort) begin
          state_d = S_DONE;
        end else if (cnt_q == SETUP_LAST) begin
          go_high = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HIGH: begin
        // Abort is deliberately not looked at here so the driver never sees a runt pulse.
        if (cnt_q == PULSE_LAST) begin
          state_d = S_LOW;
          cnt_d   = 32'd0;
          steps_d = steps_q - 32'd1;
`ifdef STEPPER_POSITION_EN
          pos_d   = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_LOW: begin
        if (cnt_q == low_last) begin
          if (steps_q == 32'd0 || bus.cmd_abort) begin
            state_d = S_DONE;
          end else begin
            go_high = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared gate in front of every rising edge: abort or the leading endstop end the move.
    if (go_high) begin
      if (bus.cmd_abort) begin
        state_d = S_DONE;
      end else if (es_block) begin
        hit_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        state_d = S_HIGH;
        cnt_d   = 32'd0;
      end
    end

    step_d = (state_d == S_HIGH);
    busy_d = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
    en_n_d = !busy_d;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 32'd0;
      steps_q       <= 32'd0;
      period_q      <= MIN_P;
      dir_q         <= 1'b1;
      hit_q         <= 1'b0;
      step_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      en_n_q        <= 1'b1;
      es_min_sync_q <= 2'b00;
      es_max_sync_q <= 2'b00;
`ifdef STEPPER_POSITION_EN
      pos_q         <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      steps_q       <= steps_d;
      period_q      <= period_d;
      dir_q         <= dir_d;
      hit_q         <= hit_d;
      step_q        <= step_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      en_n_q        <= en_n_d;
      es_min_sync_q <= {es_min_sync_q[0], bus.endstop_min};
      es_max_sync_q <= {es_max_sync_q[0], bus.endstop_max};
`ifdef STEPPER_POSITION_EN
      pos_q         <= pos_d;
`endif
    end
  end

  assign bus.step_out     = step_q;
  assign bus.dir_out      = dir_q;
  assign bus.enable_n_out = en_n_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.hit_endstop  = hit_q;
  assign bus.steps_left   = steps_q;
`ifdef STEPPER_POSITION_EN
  assign bus.position     = pos_q;
`endif

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// tb/tb_stepper_axis_ctrl.sv - directed and randomized moves checked against a timeline model
// The model predicts every cycle of a move from start time, pulse count and effective period.
module tb_stepper_axis_ctrl;
  localparam int unsigned PW = 100;
  localparam int unsigned DS = 50;
  localparam int unsigned MP = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  stepper_axis_ctrl_if bus ();

  stepper_axis_ctrl #(
    .PULSE_W   (PW),
    .DIR_SETUP (DS),
    .MIN_PERIOD(MP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int unsigned m_n, m_k, m_eff, m_base, m_d;
  logic        m_dir, m_hit;
  int          m_pos0;
  int          cur_pos = 0;

  function automatic logic [69:0] pack(input logic st, input logic dr, input logic en_n,
                                       input logic bz, input logic dn, input logic ht,
                                       input logic [31:0] left, input logic [31:0] pos);
`ifdef STEPPER_POSITION_EN
    return {st, dr, en_n, bz, dn, ht, left, pos};
`else
    return {st, dr, en_n, bz, dn, ht, left, 32'd0 & pos};
`endif
  endfunction

  function automatic logic [69:0] obs();
`ifdef STEPPER_POSITION_EN
    return pack(bus.step_out, bus.dir_out, bus.enable_n_out, bus.busy, bus.done,
                bus.hit_endstop, bus.steps_left, bus.position);
`else
    return pack(bus.step_out, bus.dir_out, bus.enable_n_out, bus.busy, bus.done,
                bus.hit_endstop, bus.steps_left, 32'd0);
`endif
  endfunction

  // Expected outputs rel cycles after the edge that sampled cmd_start.
  function automatic logic [69:0] model(input int unsigned rel);
    int unsigned i, ph, comp;
    int          p;
    if (rel >= m_d) begin
      comp = m_k;
      p = m_dir ? m_pos0 + int'(comp) : m_pos0 - int'(comp);
      return pack(1'b0, m_dir, 1'b1, 1'b0, rel == m_d, m_hit, m_n - comp, p);
    end
    if (rel < m_base) begin
      return pack(1'b0, m_dir, 1'b0, 1'b1, 1'b0, 1'b0, m_n, m_pos0);
    end
    i = (rel - m_base) / m_eff;
    ph = (rel - m_base) % m_eff;
    comp = i + ((ph >= PW) ? 1 : 0);
    p = m_dir ? m_pos0 + int'(comp) : m_pos0 - int'(comp);
    return pack(ph < PW, m_dir, 1'b0, 1'b1, 1'b0, 1'b0, m_n - comp, p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [69:0] exp_v);
    logic [69:0] o;
    o = obs();
    vectors++;
    assert (o === exp_v) else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, o, exp_v);
    end
  endtask

  // es_which: 0 none, 1 endstop_max, 2 endstop_min; raised during the LOW after pulse es_after.
  task automatic run_move(input string tag, input logic [31:0] steps, input int unsigned period,
                          input int abort_p, input int es_after, input int es_which,
                          input bit restart);
    bit active;
    m_n    = steps[31] ? (~steps + 32'd1) : steps;
    m_dir  = ~steps[31];
    m_eff  = (period < MP) ? MP : period;
    m_base = DS + 1;
    m_k    = m_n;
    m_hit  = 1'b0;
    m_pos0 = cur_pos;
    if (abort_p >= 0 && abort_p < int'(m_n)) m_k = abort_p + 1;
    active = (es_which == 1 && m_dir) || (es_which == 2 && !m_dir);
    if (active && es_after >= 1 && es_after < int'(m_k)) begin
      m_k = es_after;
      m_hit = 1'b1;
    end
    m_d = (m_n == 0) ? 0 : m_base + m_k * m_eff;

    bus.cmd_steps  = steps;
    bus.cmd_period = period;
    bus.cmd_start  = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    for (int unsigned rel = 0; rel <= m_d + 2; rel++) begin
      check(tag, model(rel));
      bus.cmd_start = 1'b0;
      if (abort_p >= 0 && abort_p < int'(m_n) && rel == m_base + abort_p * m_eff + 20)
        bus.cmd_abort = 1'b1;
      if (es_which != 0 && es_after >= 1 && rel == m_base + (es_after - 1) * m_eff + PW + 10) begin
        if (es_which == 1) bus.endstop_max = 1'b1;
        else bus.endstop_min = 1'b1;
      end
      if (restart && m_n != 0 && rel == m_base + m_eff / 2) begin
        bus.cmd_steps = 32'd99;
        bus.cmd_start = 1'b1;
      end
      tick();
    end
    bus.cmd_abort   = 1'b0;
    bus.endstop_max = 1'b0;
    bus.endstop_min = 1'b0;
    cur_pos = m_dir ? m_pos0 + int'(m_k) : m_pos0 - int'(m_k);
  endtask

  initial begin
    logic [31:0] rs;
    int          ab, ea, ew;
    bus.cmd_start   = 1'b0;
    bus.cmd_steps   = 32'd0;
    bus.cmd_period  = 32'd0;
    bus.cmd_abort   = 1'b0;
    bus.endstop_min = 1'b0;
    bus.endstop_max = 1'b0;
`ifdef STEPPER_POSITION_EN
    bus.pos_clear   = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) tick();
    check("reset", pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    reset = 1'b0;
    tick();
    check("idle", pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));

    run_move("fwd5", 32'd5, 400, -1, 0, 0, 1'b0);
`ifdef STEPPER_POSITION_EN
    bus.pos_clear = 1'b1;
    tick();
    bus.pos_clear = 1'b0;
    cur_pos = 0;
    vectors++;
    assert (bus.position === 32'd0) else begin
      miscompares++;
      $error("FAIL pos_clear obs=%h exp=%h", bus.position, 32'd0);
    end
`endif
    run_move("rev3_clamp", -32'sd3, 50, -1, 0, 0, 1'b0);
    run_move("zero", 32'd0, 300, -1, 0, 0, 1'b0);
    run_move("es_max", 32'd10, 300, -1, 4, 1, 1'b0);
    run_move("es_min_ignored", 32'd10, 300, -1, 4, 2, 1'b0);
    run_move("es_min_rev", -32'sd4, 250, -1, 2, 2, 1'b0);
    run_move("abort_high", 32'd6, 220, 2, 0, 0, 1'b0);
    run_move("restart_ignored", 32'd3, 210, -1, 0, 0, 1'b1);

    bus.cmd_steps = 32'd7;
    bus.cmd_abort = 1'b1;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("start_with_abort", model(m_d + 10));
      tick();
    end

    for (int r = 0; r < 8; r++) begin
      rs = 32'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) rs = ~rs + 32'd1;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      ea = int'($urandom_range(1, 4));
      ew = int'($urandom_range(0, 2));
      run_move("random", rs, $urandom_range(150, 330), ab, ea, ew, 1'($urandom_range(0, 1)));
    end

    // Largest magnitude, then reset while the first pulse is high.
    m_n = 32'h8000_0000; m_dir = 1'b0; m_eff = MP; m_base = DS + 1;
    m_k = 32'h8000_0000; m_hit = 1'b0; m_pos0 = cur_pos; m_d = 32'hFFFF_FFFF;
    bus.cmd_steps  = 32'h8000_0000;
    bus.cmd_period = 32'd0;
    bus.cmd_start  = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    for (int unsigned rel = 0; rel <= 60; rel++) begin
      check("min_int", model(rel));
      tick();
    end
    reset = 1'b1;
    tick();
    check("reset_mid_high", pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    reset = 1'b0;
    cur_pos = 0;
    tick();
    check("after_reset", pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
